// File: rtl/roclk_seq_hs.sv
// roclk_seq_hs: sequential two-layer binary neural network classifier with start/valid/ready handshake.
// Ports: clk, rst (async, active-high); start/features/in_ready accept a request in IDLE;
// out_valid/out_ready/prediction/score deliver the argmax class and its popcount score in DONE.
module roclk_seq_hs #(
  parameter int FEAT_CNT = 4,
  parameter int FEAT_BITS = 4,
  parameter int HIDDEN_CNT = 4,
  parameter int CLASS_CNT = 4,
  parameter int PAR = 1,
  parameter logic [HIDDEN_CNT*FEAT_CNT-1:0] Weights0 = '0,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] Weights1 = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [FEAT_CNT*FEAT_BITS-1:0]      features,
  output logic                               in_ready,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [$clog2(CLASS_CNT)-1:0]       prediction,
  output logic [$clog2(HIDDEN_CNT+1)-1:0]    score
);
  localparam int SW = FEAT_BITS + $clog2(FEAT_CNT) + 1;
  localparam int NG = HIDDEN_CNT / PAR;
  localparam int GW = NG > 1 ? $clog2(NG) : 1;
  localparam int CW = $clog2(CLASS_CNT);
  localparam int SCW = $clog2(HIDDEN_CNT + 1);
  typedef enum logic [1:0] {IDLE, HIDDEN, CLASS, DONE} state_t;
  state_t state_q;
  logic [FEAT_CNT*FEAT_BITS-1:0] feat_q;
  logic [HIDDEN_CNT-1:0] hid_q, hid_d, agree;
  logic [GW-1:0] g_q;
  logic [CW-1:0] c_q, idx_q, idx_d;
  logic [SCW-1:0] best_q, best_d, s_c;
  logic take;
  function automatic logic fire(input logic [FEAT_CNT-1:0] w, input logic [FEAT_CNT*FEAT_BITS-1:0] f);
    logic signed [SW-1:0] s;
    s = '0;
    for (int i = 0; i < FEAT_CNT; i++)
      s = w[i] ? s + SW'(f[i*FEAT_BITS +: FEAT_BITS]) : s - SW'(f[i*FEAT_BITS +: FEAT_BITS]);
    return !s[SW-1];
  endfunction
  // Shifts select the active weight rows so every index stays width-exact.
  always_comb begin
    hid_d = hid_q;
    for (int p = 0; p < PAR; p++)
      hid_d = (hid_d & ~(HIDDEN_CNT'(1) << (int'(g_q) * PAR + p)))
            | (HIDDEN_CNT'(fire(FEAT_CNT'(Weights0 >> ((int'(g_q) * PAR + p) * FEAT_CNT)), feat_q))
               << (int'(g_q) * PAR + p));
    agree = ~(hid_q ^ HIDDEN_CNT'(Weights1 >> (int'(c_q) * HIDDEN_CNT)));
    s_c = '0;
    for (int j = 0; j < HIDDEN_CNT; j++) s_c = s_c + SCW'(agree[j]);
    take = (c_q == '0) || (s_c > best_q);
    best_d = take ? s_c : best_q;
    idx_d = take ? c_q : idx_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      prediction <= '0;
      score <= '0;
      feat_q <= '0;
      hid_q <= '0;
      g_q <= '0;
      c_q <= '0;
      idx_q <= '0;
      best_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          feat_q <= features;
          hid_q <= '0;
          g_q <= '0;
          in_ready <= 1'b0;
          state_q <= HIDDEN;
        end
        HIDDEN: begin
          hid_q <= hid_d;
          g_q <= g_q + 1'b1;
          if (g_q == GW'(NG - 1)) begin
            c_q <= '0;
            state_q <= CLASS;
          end
        end
        CLASS: begin
          best_q <= best_d;
          idx_q <= idx_d;
          c_q <= c_q + 1'b1;
          if (c_q == CW'(CLASS_CNT - 1)) begin
            prediction <= idx_d;
            score <= best_d;
            out_valid <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_roclk_seq_hs.sv
// tb_roclk_seq_hs: self-checking bench running five weight configurations of roclk_seq_hs in lockstep.
module tb_roclk_seq_hs;
  localparam logic [15:0] W0S [5] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h3C96};
  localparam logic [11:0] W1S [5] = '{12'h3F0, 12'h3F0, 12'hAAA, 12'h3F0, 12'h695};
  localparam int PARS [5] = '{1, 1, 1, 2, 2};
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [15:0] features = '0;
  logic [4:0] ir, ov;
  logic [1:0] pr [5];
  logic [2:0] sc [5];
  int npass = 0, ntot = 0;
  always #5 clk = ~clk;
  for (genvar k = 0; k < 5; k++) begin : g
    roclk_seq_hs #(.FEAT_CNT(4), .FEAT_BITS(4), .HIDDEN_CNT(4), .CLASS_CNT(3), .PAR(PARS[k]),
                   .Weights0(W0S[k]), .Weights1(W1S[k])) u (
      .clk(clk), .rst(rst), .start(start), .features(features), .in_ready(ir[k]),
      .out_valid(ov[k]), .out_ready(out_ready), .prediction(pr[k]), .score(sc[k]));
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Reference: signed neuron sums, then class agreement counts with first-best argmax.
  task automatic model(input int k, input logic [15:0] f, output int p, output int s);
    logic [15:0] w0;
    logic [11:0] w1;
    int h [4];
    int sum, cnt;
    w0 = W0S[k];
    w1 = W1S[k];
    s = -1;
    p = 0;
    for (int j = 0; j < 4; j++) begin
      sum = 0;
      for (int i = 0; i < 4; i++) sum += w0[j*4+i] ? int'(f[i*4 +: 4]) : -int'(f[i*4 +: 4]);
      h[j] = (sum >= 0) ? 1 : 0;
    end
    for (int c = 0; c < 3; c++) begin
      cnt = 0;
      for (int j = 0; j < 4; j++) cnt += (h[j] == int'(w1[c*4+j])) ? 1 : 0;
      if (cnt > s) begin
        s = cnt;
        p = c;
      end
    end
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, ir, 5'h1F);
    chk({tag, "_out_valid"}, ov, 5'h00);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s_pred%0d", tag, k), pr[k], 0);
      chk($sformatf("%s_score%0d", tag, k), sc[k], 0);
    end
  endtask
  task automatic run(input logic [15:0] f, input bit ready);
    int lat [5], dur [5], ep [5], es [5], el;
    bit busy_bad [5];
    for (int k = 0; k < 5; k++) begin
      lat[k] = 0;
      dur[k] = 0;
      busy_bad[k] = 1'b0;
      model(k, f, ep[k], es[k]);
    end
    features = f;
    out_ready = ready;
    start = 1'b1;
    chk("idle_in_ready", ir, 5'h1F);
    tick;
    start = 1'b0;
    features = 16'($urandom);
    for (int n = 1; n <= 12; n++) begin
      if (!ready && n >= 8) begin
        start = 1'b1;
        features = 16'($urandom);
      end
      tick;
      for (int k = 0; k < 5; k++)
        if (ov[k]) begin
          if (lat[k] == 0) lat[k] = n;
          dur[k]++;
        end else if (lat[k] == 0 && ir[k]) busy_bad[k] = 1'b1;
    end
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      el = (PARS[k] == 1) ? 7 : 5;
      chk($sformatf("latency%0d f=%h", k, f), lat[k], el);
      chk($sformatf("valid_cycles%0d f=%h", k, f), dur[k], ready ? 1 : 13 - el);
      chk($sformatf("prediction%0d f=%h", k, f), pr[k], ep[k]);
      chk($sformatf("score%0d f=%h", k, f), sc[k], es[k]);
      chk($sformatf("busy_in_ready%0d", k), busy_bad[k], 0);
    end
    if (!ready) begin
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
    end
    chk("release_in_ready", ir, 5'h1F);
    chk("release_out_valid", ov, 5'h00);
  endtask
  initial begin
    bit seen;
    tick;
    tick;
    check_reset("por");
    rst = 1'b0;
    tick;
    run(16'h3107, 1'b1);
    run(16'h0001, 1'b0);
    run(16'h0000, 1'b1);
    features = 16'h3107;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    check_reset("midrun");
    tick;
    rst = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick;
      if (ov != 5'h00) seen = 1'b1;
    end
    chk("aborted_result", seen, 0);
    run(16'h3107, 1'b1);
    for (int r = 0; r < 20; r++) run(16'($urandom), 1'($urandom));
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
